baccarat_match_fsm: RTL

Parametrised successor to the single-hand baccarat controller. Sequences card loads for each hand using the standard third-card rules and decides each hand's result. Adds tallying over a configurable multi-round match and reports the match winner. Sits between the slow_clock/key debouncer and the card/score datapath, which supplies pscore, dscore and pcard3.

---
 rtl/baccarat_match_fsm.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/baccarat_match_fsm.sv
// Baccarat match controller.
//
// Sequences the card loads of each hand using the standard third-card rules.
// It decides each hand's result and tallies results over a match of
// NUM_ROUNDS hands, then reports the match winner.
//
// Ports:
//   slow_clock        state clock, rising edge
//   resetb            asynchronous active-low reset
//   new_match         in DONE, starts a new match on the next edge
//   pscore, dscore    player/dealer hand scores (0..9) from the datapath
//   pcard3            player third-card value (0..9)
//   clear_hands       datapath clears all card registers
//   load_[pd]card[1-3] one-hot card load strobes
//   player_win_light, dealer_win_light  hand result (END) or match result (DONE)
//   endround          high for the END cycle of each hand
//   match_over        high while in DONE
//   round_num         completed hands in the current match
//   player_wins, dealer_wins, ties      match tallies (saturating)
//
// Optional feature macro: BACCARAT_EARLY_WIN_EN
//   When defined, the match ends as soon as one side's lead can no longer be
//   overcome by the remaining hands.

module baccarat_match_fsm #(
  parameter int unsigned NUM_ROUNDS = 5,
  parameter int unsigned CNT_W      = 4
) (
  input  logic             slow_clock,
  input  logic             resetb,
  input  logic             new_match,
  input  logic [3:0]       pscore,
  input  logic [3:0]       dscore,
  input  logic [3:0]       pcard3,
  output logic             clear_hands,
  output logic             load_pcard1,
  output logic             load_pcard2,
  output logic             load_pcard3,
  output logic             load_dcard1,
  output logic             load_dcard2,
  output logic             load_dcard3,
  output logic             player_win_light,
  output logic             dealer_win_light,
  output logic             endround,
  output logic             match_over,
  output logic [CNT_W-1:0] round_num,
  output logic [CNT_W-1:0] player_wins,
  output logic [CNT_W-1:0] dealer_wins,
  output logic [CNT_W-1:0] ties
);

  typedef enum logic [3:0] {
    StRst  = 4'd0,
    StPc1  = 4'd1,
    StDc1  = 4'd2,
    StPc2  = 4'd3,
    StDc2  = 4'd4,
    StPc3  = 4'd5,
    StDc3  = 4'd6,
    StEnd  = 4'd7,
    StDone = 4'd8
  } state_e;

  localparam logic [CNT_W-1:0] CntMax    = '1;
  localparam logic [CNT_W-1:0] NumRounds = CNT_W'(NUM_ROUNDS);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CntMax) ? v : v + 1'b1;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] round_q, round_d;
  logic [CNT_W-1:0] pwins_q, pwins_d;
  logic [CNT_W-1:0] dwins_q, dwins_d;
  logic [CNT_W-1:0] ties_q, ties_d;

  logic             natural;
  logic             dealer_draws;
  logic             p_gt, d_gt;
  logic [CNT_W-1:0] round_inc, pwins_upd, dwins_upd, ties_upd;
  logic             early_done;

  assign natural = (pscore == 4'd8) || (pscore == 4'd9) ||
                   (dscore == 4'd8) || (dscore == 4'd9);

  // Dealer third-card rule once the player has drawn; dscore is the two-card total.
  always_comb begin
    dealer_draws = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: dealer_draws = 1'b1;
      4'd3:             dealer_draws = (pcard3 != 4'd8);
      4'd4:             dealer_draws = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
      4'd5:             dealer_draws = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
      4'd6:             dealer_draws = (pcard3 >= 4'd6) && (pcard3 <= 4'd7);
      default:          dealer_draws = 1'b0;
    endcase
  end

  assign p_gt      = pscore > dscore;
  assign d_gt      = dscore > pscore;
  assign round_inc = sat_inc(round_q);
  assign pwins_upd = p_gt ? sat_inc(pwins_q) : pwins_q;
  assign dwins_upd = d_gt ? sat_inc(dwins_q) : dwins_q;
  assign ties_upd  = (!p_gt && !d_gt) ? sat_inc(ties_q) : ties_q;

`ifdef BACCARAT_EARLY_WIN_EN
  // One extra bit so the lead-plus-remaining sums cannot overflow.
  logic [CNT_W:0] rem;
  assign rem        = {1'b0, NumRounds} - {1'b0, round_inc};
  assign early_done = ({1'b0, pwins_upd} > ({1'b0, dwins_upd} + rem)) ||
                      ({1'b0, dwins_upd} > ({1'b0, pwins_upd} + rem));
`else
  assign early_done = 1'b0;
`endif

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= StRst;
      round_q <= '0;
      pwins_q <= '0;
      dwins_q <= '0;
      ties_q  <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      pwins_q <= pwins_d;
      dwins_q <= dwins_d;
      ties_q  <= ties_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    round_d          = round_q;
    pwins_d          = pwins_q;
    dwins_d          = dwins_q;
    ties_d           = ties_q;
    clear_hands      = 1'b0;
    load_pcard1      = 1'b0;
    load_pcard2      = 1'b0;
    load_pcard3      = 1'b0;
    load_dcard1      = 1'b0;
    load_dcard2      = 1'b0;
    load_dcard3      = 1'b0;
    player_win_light = 1'b0;
    dealer_win_light = 1'b0;
    endround         = 1'b0;
    match_over       = 1'b0;

    case (state_q)
      StRst: begin
        clear_hands = 1'b1;
        state_d     = StPc1;
      end
      StPc1: begin
        load_pcard1 = 1'b1;
        state_d     = StDc1;
      end
      StDc1: begin
        load_dcard1 = 1'b1;
        state_d     = StPc2;
      end
      StPc2: begin
        load_pcard2 = 1'b1;
        state_d     = StDc2;
      end
      StDc2: begin
        load_dcard2 = 1'b1;
        if (natural)                               state_d = StEnd;
        else if (pscore <= 4'd5)                   state_d = StPc3;
        else if (pscore <= 4'd7 && dscore <= 4'd5) state_d = StDc3;
        else                                       state_d = StEnd;
      end
      StPc3: begin
        load_pcard3 = 1'b1;
        state_d     = dealer_draws ? StDc3 : StEnd;
      end
      StDc3: begin
        load_dcard3 = 1'b1;
        state_d     = StEnd;
      end
      StEnd: begin
        endround         = 1'b1;
        player_win_light = !d_gt;
        dealer_win_light = !p_gt;
        round_d          = round_inc;
        pwins_d          = pwins_upd;
        dwins_d          = dwins_upd;
        ties_d           = ties_upd;
        state_d          = (round_inc == NumRounds || early_done) ? StDone : StRst;
      end
      StDone: begin
        match_over       = 1'b1;
        player_win_light = pwins_q >= dwins_q;
        dealer_win_light = dwins_q >= pwins_q;
        if (new_match) begin
          state_d = StRst;
          round_d = '0;
          pwins_d = '0;
          dwins_d = '0;
          ties_d  = '0;
        end
      end
      // Illegal encodings recover to RST; tallies are left alone.
      default: state_d = StRst;
    endcase
  end

  assign round_num   = round_q;
  assign player_wins = pwins_q;
  assign dealer_wins = dwins_q;
  assign ties        = ties_q;

endmodule
